axi_rd_arb2: RTL and testbench

- Two-master to one-slave AXI4 read-channel arbiter.
- Shares the testbench AXI4 memory/mailbox slave between instruction-fetch (m0) and load/store (m1) read ports.
- Arbitrates AR, tags the downstream ID with the winning master index and routes R beats back by that tag.
- Limits per-master outstanding bursts.

---
 rtl/axi_rd_arb2_if.sv | 28 ++
 rtl/axi_rd_arb2.sv | 125 ++++++++++++
 tb/tb_axi_rd_arb2.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb2_if.sv
// AXI4 read-channel bundle (AR + R) shared by the upstream masters and the slave port.
interface axi_rd_arb2_if #(
    parameter int unsigned IDW = 4
);
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [IDW-1:0]  arid;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [2:0]      arsize;
    logic            rvalid;
    logic            rready;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic [IDW-1:0]  rid;
    logic            rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arburst, arsize, rready,
        input  arready, rvalid, rdata, rresp, rid, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arburst, arsize, rready,
        output arready, rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/axi_rd_arb2.sv
// Two-master AXI4 read arbiter: tags AR IDs with the grant index and routes R beats by that tag.
// Optional macro AXI_RD_ARB_RR_EN selects round-robin tie-break (default: m0 fixed priority).
module axi_rd_arb2 #(
    parameter int unsigned TAGW     = 4,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic              aclk,
    input  logic              rst_l,
    axi_rd_arb2_if.slave      m0_if,
    axi_rd_arb2_if.slave      m1_if,
    axi_rd_arb2_if.master     s_if,
    output logic              rsp_err
);

    localparam int unsigned CNTW = 4;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_st_e;

    arb_st_e          st_q;
    logic             grant_q;
    logic             grant;
    logic [CNTW-1:0]  cnt0_q, cnt1_q;
    logic             elig0, elig1, elig_g;
    logic             ar_hs, dst, r_last_hs;
    logic             inc0, inc1, dec0, dec1, err_hit;

`ifdef AXI_RD_ARB_RR_EN
    logic             last_grant_q;
`endif

    // Eligibility uses registered counts, so a completion cannot unblock a grant in the same cycle
    assign elig0 = m0_if.arvalid && (cnt0_q < CNTW'(MAX_OUTS));
    assign elig1 = m1_if.arvalid && (cnt1_q < CNTW'(MAX_OUTS));

    always_comb begin
        grant = grant_q;
        if (st_q == ARB_OPEN) begin
`ifdef AXI_RD_ARB_RR_EN
            if (elig0 && elig1) grant = ~last_grant_q;
            else                grant = elig1;
`else
            grant = elig1 && !elig0;
`endif
        end
    end

    assign elig_g          = grant ? elig1 : elig0;
    assign s_if.arvalid    = rst_l && elig_g;
    assign ar_hs           = s_if.arvalid && s_if.arready;
    assign m0_if.arready   = ar_hs && !grant;
    assign m1_if.arready   = ar_hs && grant;

    assign s_if.araddr     = grant ? m1_if.araddr  : m0_if.araddr;
    assign s_if.arlen      = grant ? m1_if.arlen   : m0_if.arlen;
    assign s_if.arburst    = grant ? m1_if.arburst : m0_if.arburst;
    assign s_if.arsize     = grant ? m1_if.arsize  : m0_if.arsize;
    assign s_if.arid       = {grant, (grant ? m1_if.arid : m0_if.arid)};

    // R path: the top ID bit selects the destination master
    assign dst             = s_if.rid[TAGW];
    assign m0_if.rvalid    = rst_l && s_if.rvalid && !dst;
    assign m1_if.rvalid    = rst_l && s_if.rvalid && dst;
    assign s_if.rready     = rst_l && (dst ? m1_if.rready : m0_if.rready);

    assign m0_if.rdata     = s_if.rdata;
    assign m1_if.rdata     = s_if.rdata;
    assign m0_if.rresp     = s_if.rresp;
    assign m1_if.rresp     = s_if.rresp;
    assign m0_if.rlast     = s_if.rlast;
    assign m1_if.rlast     = s_if.rlast;
    assign m0_if.rid       = s_if.rid[TAGW-1:0];
    assign m1_if.rid       = s_if.rid[TAGW-1:0];

    assign r_last_hs       = s_if.rvalid && s_if.rready && s_if.rlast;
    assign inc0            = ar_hs && !grant;
    assign inc1            = ar_hs && grant;
    assign dec0            = r_last_hs && !dst;
    assign dec1            = r_last_hs && dst;
    assign err_hit         = (dec0 && (cnt0_q == '0)) || (dec1 && (cnt1_q == '0));

    // A completion against an empty counter is flagged, never wrapped
    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] cnt,
                                                 input logic inc, input logic dec);
        logic [CNTW-1:0] n;
        n = cnt;
        if (inc && !dec)                      n = cnt + CNTW'(1);
        else if (dec && !inc && cnt != '0)    n = cnt - CNTW'(1);
        return n;
    endfunction

    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            st_q         <= ARB_OPEN;
            grant_q      <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            rsp_err      <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            cnt0_q <= cnt_next(cnt0_q, inc0, dec0);
            cnt1_q <= cnt_next(cnt1_q, inc1, dec1);
            if (err_hit) rsp_err <= 1'b1;
`ifdef AXI_RD_ARB_RR_EN
            if (ar_hs) last_grant_q <= grant;
`endif
            case (st_q)
                ARB_OPEN: begin
                    if (s_if.arvalid && !s_if.arready) begin
                        st_q    <= ARB_LOCKED;
                        grant_q <= grant;
                    end
                end
                ARB_LOCKED: begin
                    if (ar_hs) st_q <= ARB_OPEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Scoreboard bench for axi_rd_arb2: directed AR/R stimulus, expected handshakes checked by a monitor.
module tb_axi_rd_arb2;

    localparam int unsigned TAGW = 4;

    logic aclk  = 1'b0;
    logic rst_l = 1'b1;
    logic rsp_err;

    always #5 aclk = ~aclk;

    axi_rd_arb2_if #(.IDW(TAGW))     m0();
    axi_rd_arb2_if #(.IDW(TAGW))     m1();
    axi_rd_arb2_if #(.IDW(TAGW + 1)) s();

    axi_rd_arb2 #(.TAGW(TAGW), .MAX_OUTS(4)) dut (
        .aclk    (aclk),
        .rst_l   (rst_l),
        .m0_if   (m0),
        .m1_if   (m1),
        .s_if    (s),
        .rsp_err (rsp_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  id;
    } ar_exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  id;
        logic        last;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r0_q[$];
    r_exp_t  r1_q[$];
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    // Monitor: pop an expectation for every handshake the DUT presents
    always @(negedge aclk) begin : mon
        ar_exp_t ea;
        r_exp_t  er;
        if (rst_l && s.arvalid && s.arready) begin
            if (ar_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_unexpected: got addr 0x%0h id 0x%0h expected none", s.araddr, s.arid);
            end else begin
                ea = ar_q.pop_front();
                chk("ar_addr", 64'(s.araddr), 64'(ea.addr));
                chk("ar_id",   64'(s.arid),   64'(ea.id));
            end
        end
        if (rst_l && m0.rvalid && m0.rready) begin
            if (r0_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r0_unexpected: got rid 0x%0h expected none", m0.rid);
            end else begin
                er = r0_q.pop_front();
                chk("r0_data", m0.rdata, er.data);
                chk("r0_id",   64'(m0.rid), 64'(er.id));
                chk1("r0_last", m0.rlast, er.last);
            end
        end
        if (rst_l && m1.rvalid && m1.rready) begin
            if (r1_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r1_unexpected: got rid 0x%0h expected none", m1.rid);
            end else begin
                er = r1_q.pop_front();
                chk("r1_data", m1.rdata, er.data);
                chk("r1_id",   64'(m1.rid), 64'(er.id));
                chk1("r1_last", m1.rlast, er.last);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drv_ar0(input logic v, input logic [31:0] a, input logic [3:0] id);
        m0.arvalid = v; m0.araddr = a; m0.arid = id;
    endtask

    task automatic drv_ar1(input logic v, input logic [31:0] a, input logic [3:0] id);
        m1.arvalid = v; m1.araddr = a; m1.arid = id;
    endtask

    task automatic drv_r(input logic v, input logic [4:0] id, input logic last, input logic [63:0] d);
        s.rvalid = v; s.rid = id; s.rlast = last; s.rdata = d; s.rresp = 2'b00;
    endtask

    task automatic idle();
        drv_ar0(1'b0, 32'h0, 4'h0);
        drv_ar1(1'b0, 32'h0, 4'h0);
        m0.arlen = 8'h0; m0.arburst = 2'b01; m0.arsize = 3'b011;
        m1.arlen = 8'h0; m1.arburst = 2'b01; m1.arsize = 3'b011;
        m0.rready = 1'b1; m1.rready = 1'b1;
        s.arready = 1'b0;
        drv_r(1'b0, 5'h0, 1'b0, 64'h0);
    endtask

    task automatic do_reset();
        idle();
        rst_l = 1'b0;
        @(posedge aclk);
        #1;
        rst_l = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [5:0] t2g;
        logic       g;
        int         n0, n1;

        // Reset forces every handshake output low even with live inputs
        idle();
        #1 rst_l = 1'b0;
        m0.arvalid = 1'b1; s.arready = 1'b1; s.rvalid = 1'b1; s.rid = 5'h00;
        #1;
        chk1("rst_s_arvalid", s.arvalid, 1'b0);
        chk1("rst_m0_arready", m0.arready, 1'b0);
        chk1("rst_m0_rvalid", m0.rvalid, 1'b0);
        chk1("rst_s_rready", s.rready, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        idle();
        repeat (2) @(posedge aclk);
        #1 rst_l = 1'b1;

        // Single m0 read and its response
        drv_ar0(1'b1, 32'h1000, 4'h3);
        m0.arlen = 8'h07;
        s.arready = 1'b1;
        ar_q.push_back('{addr: 32'h1000, id: 5'h03});
        #1;
        chk1("t1_s_arvalid", s.arvalid, 1'b1);
        chk1("t1_m0_arready", m0.arready, 1'b1);
        chk1("t1_m1_arready", m1.arready, 1'b0);
        chk("t1_s_arid", 64'(s.arid), 64'h03);
        chk("t1_s_arlen", 64'(s.arlen), 64'h07);
        chk("t1_s_arburst", 64'(s.arburst), 64'h1);
        chk("t1_s_arsize", 64'(s.arsize), 64'h3);
        tick();
        drv_ar0(1'b0, 32'h0, 4'h0);
        m0.arlen = 8'h0;
        drv_r(1'b1, 5'h03, 1'b1, 64'hDEAD_BEEF_0000_0003);
        r0_q.push_back('{data: 64'hDEAD_BEEF_0000_0003, id: 4'h3, last: 1'b1});
        #1;
        chk1("t1_m0_rvalid", m0.rvalid, 1'b1);
        chk1("t1_m1_rvalid", m1.rvalid, 1'b0);
        chk("t1_m0_rid", 64'(m0.rid), 64'h3);
        chk1("t1_s_rready", s.rready, 1'b1);
        tick();
        drv_r(1'b0, 5'h0, 1'b0, 64'h0);

        // m0 fills its four slots (cnt0 back at 0 after the read above), then is blocked
        for (int i = 0; i < 4; i++) begin
            drv_ar0(1'b1, 32'h6000 + 32'(i) * 32'h40, 4'(i));
            ar_q.push_back('{addr: 32'h6000 + 32'(i) * 32'h40, id: {1'b0, 4'(i)}});
            #1;
            chk1("t4_arvalid_ok", s.arvalid, 1'b1);
            tick();
        end
        drv_ar0(1'b1, 32'h6100, 4'h9);
        ar_q.push_back('{addr: 32'h6100, id: 5'h09});
        #1;
        chk1("t4_blocked_arvalid", s.arvalid, 1'b0);
        chk1("t4_blocked_arready", m0.arready, 1'b0);
        tick();
        chk1("t4_still_blocked", s.arvalid, 1'b0);
        drv_r(1'b1, 5'h02, 1'b1, 64'h0000_0000_0000_6002);
        r0_q.push_back('{data: 64'h0000_0000_0000_6002, id: 4'h2, last: 1'b1});
        #1;
        chk1("t4_blocked_on_completion", s.arvalid, 1'b0);
        tick();
        drv_r(1'b0, 5'h0, 1'b0, 64'h0);
        #1;
        chk1("t4_unblocked_arvalid", s.arvalid, 1'b1);
        chk1("t4_unblocked_arready", m0.arready, 1'b1);
        tick();
        drv_ar0(1'b0, 32'h0, 4'h0);

        // Both masters requesting every cycle
        do_reset();
`ifdef AXI_RD_ARB_RR_EN
        t2g = 6'b101010;
`else
        t2g = 6'b110000;
`endif
        n0 = 0; n1 = 0;
        s.arready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            g = t2g[i];
            drv_ar0(1'b1, 32'h2000 + 32'(n0) * 32'h10, 4'(n0));
            drv_ar1(1'b1, 32'h3000 + 32'(n1) * 32'h10, 4'(n1));
            if (g) ar_q.push_back('{addr: 32'h3000 + 32'(n1) * 32'h10, id: {1'b1, 4'(n1)}});
            else   ar_q.push_back('{addr: 32'h2000 + 32'(n0) * 32'h10, id: {1'b0, 4'(n0)}});
            #1;
            chk1("t2_m0_arready", m0.arready, !g);
            chk1("t2_m1_arready", m1.arready, g);
            tick();
            if (g) n1++; else n0++;
        end
        idle();

        // Stalled m1 request holds the grant while m0 joins
        do_reset();
        drv_ar1(1'b1, 32'h4000, 4'h7);
        #1;
        chk1("t3_s_arvalid", s.arvalid, 1'b1);
        chk("t3_araddr_c1", 64'(s.araddr), 64'h4000);
        chk1("t3_m1_arready_c1", m1.arready, 1'b0);
        tick();
        drv_ar0(1'b1, 32'h5000, 4'h1);
        #1;
        chk("t3_araddr_c2", 64'(s.araddr), 64'h4000);
        chk("t3_arid_c2", 64'(s.arid), 64'h17);
        chk1("t3_m0_arready_c2", m0.arready, 1'b0);
        tick();
        chk("t3_araddr_c3", 64'(s.araddr), 64'h4000);
        chk1("t3_m0_arready_c3", m0.arready, 1'b0);
        s.arready = 1'b1;
        ar_q.push_back('{addr: 32'h4000, id: 5'h17});
        #1;
        chk1("t3_m1_arready_hs", m1.arready, 1'b1);
        chk1("t3_m0_arready_hs", m0.arready, 1'b0);
        tick();
        drv_ar1(1'b0, 32'h0, 4'h0);
        ar_q.push_back('{addr: 32'h5000, id: 5'h01});
        #1;
        chk1("t3_m0_arready_after", m0.arready, 1'b1);
        tick();
        idle();

        // Simultaneous m1 AR handshake and m1 completion keep cnt1 at 2
        do_reset();
        s.arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv_ar1(1'b1, 32'h7000 + 32'(i) * 32'h40, 4'(i));
            ar_q.push_back('{addr: 32'h7000 + 32'(i) * 32'h40, id: {1'b1, 4'(i)}});
            tick();
        end
        drv_ar1(1'b1, 32'h7080, 4'h2);
        ar_q.push_back('{addr: 32'h7080, id: 5'h12});
        drv_r(1'b1, 5'h10, 1'b1, 64'h0000_0000_0000_7000);
        r1_q.push_back('{data: 64'h0000_0000_0000_7000, id: 4'h0, last: 1'b1});
        #1;
        chk1("t5_m1_arready", m1.arready, 1'b1);
        chk1("t5_m1_rvalid", m1.rvalid, 1'b1);
        tick();
        drv_r(1'b0, 5'h0, 1'b0, 64'h0);
        for (int i = 3; i < 5; i++) begin
            drv_ar1(1'b1, 32'h7000 + 32'(i) * 32'h40, 4'(i));
            ar_q.push_back('{addr: 32'h7000 + 32'(i) * 32'h40, id: {1'b1, 4'(i)}});
            #1;
            chk1("t5_arvalid_ok", s.arvalid, 1'b1);
            tick();
        end
        drv_ar1(1'b1, 32'h7200, 4'h5);
        #1;
        chk1("t5_blocked", s.arvalid, 1'b0);
        tick();
        idle();

        // Orphan completion for m1 sets the sticky error; counter stays 0
        do_reset();
        drv_r(1'b1, 5'h11, 1'b1, 64'h0000_0000_0000_0011);
        r1_q.push_back('{data: 64'h0000_0000_0000_0011, id: 4'h1, last: 1'b1});
        #1;
        chk1("t6_m1_rvalid", m1.rvalid, 1'b1);
        chk1("t6_m0_rvalid", m0.rvalid, 1'b0);
        chk1("t6_err_before", rsp_err, 1'b0);
        tick();
        drv_r(1'b0, 5'h0, 1'b0, 64'h0);
        chk1("t6_err_set", rsp_err, 1'b1);
        repeat (3) tick();
        chk1("t6_err_sticky", rsp_err, 1'b1);
        s.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv_ar1(1'b1, 32'h8000 + 32'(i) * 32'h40, 4'(i));
            ar_q.push_back('{addr: 32'h8000 + 32'(i) * 32'h40, id: {1'b1, 4'(i)}});
            #1;
            chk1("t6_cnt1_zero_ok", s.arvalid, 1'b1);
            tick();
        end
        drv_ar1(1'b1, 32'h8100, 4'h9);
        #1;
        chk1("t6_cnt1_full", s.arvalid, 1'b0);

        // Reset mid-burst with live requests and data
        drv_ar0(1'b1, 32'h8200, 4'h2);
        drv_r(1'b1, 5'h10, 1'b0, 64'h0000_0000_0000_8000);
        rst_l = 1'b0;
        #1;
        chk1("t7_s_arvalid", s.arvalid, 1'b0);
        chk1("t7_s_rready", s.rready, 1'b0);
        chk1("t7_m0_arready", m0.arready, 1'b0);
        chk1("t7_m1_arready", m1.arready, 1'b0);
        chk1("t7_m0_rvalid", m0.rvalid, 1'b0);
        chk1("t7_m1_rvalid", m1.rvalid, 1'b0);
        chk1("t7_rsp_err", rsp_err, 1'b0);
        idle();
        tick();
        rst_l = 1'b1;
        s.arready = 1'b1;
        drv_ar1(1'b1, 32'h9000, 4'h0);
        ar_q.push_back('{addr: 32'h9000, id: 5'h10});
        #1;
        chk1("t7_m1_after_reset", m1.arready, 1'b1);
        tick();
        idle();
        tick();

        chk("ar_q_empty", 64'(ar_q.size()), 64'h0);
        chk("r0_q_empty", 64'(r0_q.size()), 64'h0);
        chk("r1_q_empty", 64'(r1_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
